// File: rtl/dsp_mult_arbiter.sv
// Round-robin arbiter sharing one pipelined signed multiplier between requesters.
// Results carry the requester ID; a stalled output freezes the whole pipeline.
module dsp_mult_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int PIPE_STAGES = 2,
    parameter int ID_W        = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [2*DATA_W-1:0]         res_data,
    output logic [ID_W-1:0]             res_id,
    output logic                        busy
);

    localparam int P  = PIPE_STAGES;
    localparam int PW = 2 * DATA_W;

    logic [P-1:0]    vld_q, vld_d;
    logic [ID_W-1:0] id_q  [P];
    logic [ID_W-1:0] id_d  [P];
    logic [PW-1:0]   dat_q [P];
    logic [PW-1:0]   dat_d [P];
    logic [ID_W-1:0] ptr_q, ptr_d;

    logic                     advance;
    logic                     found;
    logic                     accept;
    logic [ID_W-1:0]          gnt;
    logic [ID_W-1:0]          idx;
    logic signed [DATA_W-1:0] sel_a, sel_b;
    logic signed [DATA_W-1:0] mul_a, mul_b;
    logic signed [PW-1:0]     prod;

    assign advance = !vld_q[P-1] || res_ready;
    assign accept  = found && advance;

    // Search upward from ptr, wrapping, for the first valid requester.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            idx = ID_W'((int'(ptr_q) + j) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
        sel_a = req_a[int'(gnt)*DATA_W +: DATA_W];
        sel_b = req_b[int'(gnt)*DATA_W +: DATA_W];
    end

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[gnt] = 1'b1;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept)
            ptr_d = (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
    end

    // Single-stage pipe multiplies straight from the grant mux.
    assign mul_a = (P == 1) ? sel_a : dat_q[0][PW-1:DATA_W];
    assign mul_b = (P == 1) ? sel_b : dat_q[0][DATA_W-1:0];
    assign prod  = mul_a * mul_b;

    // ID/data only load with a valid op so outputs hold across bubbles.
    always_comb begin
        vld_d = vld_q;
        id_d  = id_q;
        dat_d = dat_q;
        if (advance) begin
            vld_d[0] = accept;
            if (accept) begin
                id_d[0]  = gnt;
                dat_d[0] = (P == 1) ? prod : {sel_a, sel_b};
            end
            for (int i = 1; i < P; i++) begin
                vld_d[i] = vld_q[i-1];
                if (vld_q[i-1]) begin
                    id_d[i]  = id_q[i-1];
                    dat_d[i] = (i == 1) ? prod : dat_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            ptr_q <= '0;
            for (int i = 0; i < P; i++) begin
                id_q[i]  <= '0;
                dat_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            ptr_q <= ptr_d;
            id_q  <= id_d;
            dat_q <= dat_d;
        end
    end

    assign res_valid = vld_q[P-1];
    assign res_data  = dat_q[P-1];
    assign res_id    = id_q[P-1];
    assign busy      = |vld_q;

endmodule

// File: tb/tb_dsp_mult_arbiter.sv
// Randomized scoreboard bench for dsp_mult_arbiter against a latency/round-robin
// reference model; a separate monitor checks each presented result.
module tb_dsp_mult_arbiter;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int P   = 2;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*DW-1:0]   req_a;
    logic [N*DW-1:0]   req_b;
    logic              res_valid;
    logic              res_ready;
    logic [2*DW-1:0]   res_data;
    logic [IDW-1:0]    res_id;
    logic              busy;

    dsp_mult_arbiter #(
        .NUM_REQ(N), .DATA_W(DW), .PIPE_STAGES(P), .ID_W(IDW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0]  id;
        logic [2*DW-1:0] prod;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    logic [2*DW-1:0] ops [N][$];
    exp_t        exp_q [$];
    int          ages  [$];
    int          mptr  = 0;
    int          rdy_mode = 0;
    int          gen_pct  = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [2*DW-1:0] model_mul(logic [2*DW-1:0] ab);
        int pa;
        int pb;
        pa = int'($signed(ab[2*DW-1:DW]));
        pb = int'($signed(ab[DW-1:0]));
        return (2*DW)'(pa * pb);
    endfunction

    function automatic bit ops_empty();
        for (int i = 0; i < N; i++)
            if (ops[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    // One clock: drive at negedge, check against model, commit model for the coming posedge.
    task automatic step();
        bit           mvalid;
        bit           adv;
        int           g;
        int           k;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            req_valid[i] = ops[i].size() > 0;
            if (ops[i].size() > 0) begin
                req_a[i*DW +: DW] = ops[i][0][2*DW-1:DW];
                req_b[i*DW +: DW] = ops[i][0][DW-1:0];
            end
        end
        res_ready = (rdy_mode == 0) ? 1'b1 :
                    (rdy_mode == 1) ? 1'b0 : ($urandom_range(0, 99) < 70);
        #1;
        mvalid = ages.size() > 0 && ages[0] == P - 1;
        adv    = !mvalid || res_ready;
        g      = -1;
        for (int j = 0; j < N; j++) begin
            k = (mptr + j) % N;
            if (g < 0 && ops[k].size() > 0) g = k;
        end
        exp_rdy = (adv && g >= 0) ? N'(1 << g) : '0;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("res_valid", 64'(res_valid), 64'(mvalid));
        chk("busy", 64'(busy), 64'(ages.size() > 0));
        if (adv) begin
            if (mvalid) void'(ages.pop_front());
            foreach (ages[i]) ages[i]++;
            if (g >= 0) begin
                exp_q.push_back({IDW'(g), model_mul(ops[g][0])});
                void'(ops[g].pop_front());
                ages.push_back(0);
                mptr = (g + 1) % N;
            end
        end
        for (int i = 0; i < N; i++)
            if (gen_pct > 0 && $urandom_range(0, 99) < gen_pct && ops[i].size() < 3)
                ops[i].push_back(16'($urandom));
    endtask

    task automatic drain();
        int n = 0;
        while ((!ops_empty() || exp_q.size() > 0 || ages.size() > 0) && n < 300) begin
            step();
            n++;
        end
        chk("drain_timeout", 64'(n < 300), 64'd1);
    endtask

    task automatic reset_midstream();
        @(negedge clk);
        #4;
        reset_n = 1'b0;
        req_valid = '0;
        #1;
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_res_data", 64'(res_data), 64'd0);
        chk("rst_res_id", 64'(res_id), 64'd0);
        for (int i = 0; i < N; i++) ops[i].delete();
        exp_q.delete();
        ages.delete();
        mptr = 0;
        @(negedge clk);
        #4;
        reset_n = 1'b1;
    endtask

    always @(negedge clk) begin
        #2;
        if (reset_n && res_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL res_unexpected actual id=%0d data=%0h required none", res_id, res_data);
            end else begin
                chk("res_data", 64'(res_data), 64'(exp_q[0].prod));
                chk("res_id", 64'(res_id), 64'(exp_q[0].id));
                if (res_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;
        #1;
        chk("init_res_valid", 64'(res_valid), 64'd0);
        chk("init_busy", 64'(busy), 64'd0);
        chk("init_res_data", 64'(res_data), 64'd0);
        chk("init_req_ready", 64'(req_ready), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        ops[0].push_back({8'd3, 8'hFB});
        drain();

        ops[0].push_back({8'h80, 8'h80});
        ops[0].push_back({8'h80, 8'h7F});
        ops[0].push_back({8'h7F, 8'h7F});
        ops[0].push_back({8'h00, 8'hFF});
        drain();

        ops[2].push_back({8'd5, 8'd6});
        step();
        ops[1].push_back({8'd7, 8'hF9});
        ops[3].push_back({8'hF0, 8'd11});
        drain();

        ops[0].push_back({8'd10, 8'd10});
        ops[0].push_back({8'd20, 8'd3});
        ops[1].push_back({8'd9, 8'd9});
        step();
        step();
        reset_midstream();

        for (int i = 0; i < N; i++) begin
            ops[i].push_back(16'($urandom));
            ops[i].push_back(16'($urandom));
        end
        drain();

        for (int i = 0; i < N; i++)
            repeat (3) ops[i].push_back(16'($urandom));
        repeat (3) step();
        rdy_mode = 1;
        repeat (5) step();
        rdy_mode = 0;
        drain();

        gen_pct  = 30;
        rdy_mode = 2;
        repeat (400) step();
        gen_pct  = 0;
        rdy_mode = 0;
        drain();

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
